// File: rtl/ecc_iv_pkg.sv
// ecc_iv_pkg: shared types and helpers for the ECC DRBG IV collector.
package ecc_iv_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, ERR} state_t;

    function automatic int num_words(input int reg_size, input int word_w);
        return reg_size / word_w;
    endfunction

endpackage

// File: rtl/ecc_iv_collector_if.sv
// ecc_iv_collector_if: valid/ready entropy word channel feeding the IV collector.
interface ecc_iv_collector_if #(parameter int WORD_W = 32);

    logic [WORD_W-1:0] ent_data;
    logic              ent_valid;
    logic              ent_ready;

    modport master (output ent_data, output ent_valid, input ent_ready);
    modport slave  (input ent_data, input ent_valid, output ent_ready);

endinterface

// File: rtl/ecc_rep_count_check.sv
// ecc_rep_count_check: repetition-count health test; pulses fail on the word that
// completes REP_LIMIT consecutive identical accepted words.
module ecc_rep_count_check #(
    parameter int WORD_W    = 32,
    parameter int REP_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [WORD_W-1:0] word,
    input  logic              word_vld,
    output logic              fail
);

    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [WORD_W-1:0] last_word;
    logic [RW-1:0]     rep_cnt;
    logic [RW-1:0]     rep_nxt;

    // rep_cnt == 0 marks the first word since clear, so last_word is not compared
    assign rep_nxt = (rep_cnt == '0 || word != last_word) ? RW'(1) : rep_cnt + 1'b1;
    assign fail    = word_vld && rep_nxt == RW'(REP_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_word <= '0;
            rep_cnt   <= '0;
        end else if (clear) begin
            last_word <= '0;
            rep_cnt   <= '0;
        end else if (word_vld) begin
            last_word <= word;
            rep_cnt   <= rep_nxt;
        end
    end

endmodule

// File: rtl/ecc_iv_collector.sv
// ecc_iv_collector: gathers entropy words into a health-checked IV for the ECC HMAC-DRBG.
module ecc_iv_collector
    import ecc_iv_pkg::*;
#(
    parameter int REG_SIZE  = 384,
    parameter int WORD_W    = 32,
    parameter int REP_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                req,
    ecc_iv_collector_if.slave   ent,
    output logic [REG_SIZE-1:0] iv,
    output logic                iv_valid,
    output logic                busy,
    output logic                err
);

    localparam int NUM_WORDS = num_words(REG_SIZE, WORD_W);
    localparam int CW        = $clog2(NUM_WORDS + 1);

    state_t              state;
    logic [CW-1:0]       word_cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [REG_SIZE-1:0] iv_reg;
    logic [REG_SIZE-1:0] prev_iv;
    logic                xfer;
    logic                rep_fail;
    logic                clear;

    assign ent.ent_ready = state == COLLECT;
    assign xfer          = ent.ent_valid && ent.ent_ready;
    assign cnt_nxt       = word_cnt + 1'b1;
    assign busy          = state == COLLECT || state == CHECK;
    assign clear         = zeroize || (req && (state == IDLE || state == ERR));
    assign iv            = iv_valid ? iv_reg : '0;

    ecc_rep_count_check #(.WORD_W(WORD_W), .REP_LIMIT(REP_LIMIT)) u_rep (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .word     (ent.ent_data),
        .word_vld (xfer),
        .fail     (rep_fail)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            iv_reg   <= '0;
            prev_iv  <= '0;
            iv_valid <= 1'b0;
            err      <= 1'b0;
        end else if (zeroize) begin
            state    <= IDLE;
            word_cnt <= '0;
            iv_reg   <= '0;
            prev_iv  <= '0;
            iv_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE, ERR: if (req) begin
                    iv_valid <= 1'b0;
                    err      <= 1'b0;
                    word_cnt <= '0;
                    state    <= COLLECT;
                end
                COLLECT: if (xfer) begin
                    iv_reg   <= {iv_reg[REG_SIZE-WORD_W-1:0], ent.ent_data};
                    word_cnt <= cnt_nxt;
                    if (rep_fail) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else if (cnt_nxt == CW'(NUM_WORDS)) begin
                        state <= CHECK;
                    end
                end
                CHECK: if (iv_reg == prev_iv && prev_iv != '0) begin
                    err   <= 1'b1;
                    state <= ERR;
                end else begin
                    prev_iv  <= iv_reg;
                    iv_valid <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_iv_collector.sv
// tb_ecc_iv_collector: directed checks of IV assembly, backpressure, health tests and zeroize.
module tb_ecc_iv_collector;

    localparam logic [383:0] NOM_IV = 384'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008_00000009_0000000A_0000000B_0000000C;
    localparam logic [383:0] REP_IV = 384'hDEADBEEF_DEADBEEF_DEADBEEF_00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008_00000009;
    localparam logic [383:0] B100_IV = 384'h00000100_00000101_00000102_00000103_00000104_00000105_00000106_00000107_00000108_00000109_0000010A_0000010B;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         zeroize = 1'b0;
    logic         req = 1'b0;
    logic [383:0] iv;
    logic         iv_valid;
    logic         busy;
    logic         err;
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;

    ecc_iv_collector_if #(.WORD_W(32)) ent ();

    ecc_iv_collector #(.REG_SIZE(384), .WORD_W(32), .REP_LIMIT(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .zeroize  (zeroize),
        .req      (req),
        .ent      (ent),
        .iv       (iv),
        .iv_valid (iv_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        req = 1'b1;
        cyc = 0;
        tick();
        req = 1'b0;
    endtask

    // Sends n words base, base+step, ...; with toggle, ent_valid is high only in odd cycles
    task automatic feed(input logic [31:0] base, input logic [31:0] step, input int n, input bit toggle);
        int i = 0;
        int g = 0;
        while (i < n && g < 200) begin
            ent.ent_valid = toggle ? cyc[0] : 1'b1;
            ent.ent_data  = base + step * i;
            if (ent.ent_ready && ent.ent_valid) i++;
            tick();
            req = 1'b0;
            g++;
        end
        ent.ent_valid = 1'b0;
        chk("feed_words", 384'(i), 384'(n));
    endtask

    task automatic wait_valid();
        while (!iv_valid && !err && cyc < 100) tick();
    endtask

    initial begin
        ent.ent_valid = 1'b0;
        ent.ent_data  = '0;
        tick();
        tick();
        chk("rst_iv", iv, '0);
        chk("rst_iv_valid", 384'(iv_valid), 0);
        chk("rst_err", 384'(err), 0);
        chk("rst_busy", 384'(busy), 0);
        chk("rst_ready", 384'(ent.ent_ready), 0);
        reset_n = 1'b1;
        tick();

        start();
        chk("nom_busy", 384'(busy), 1);
        chk("nom_ready", 384'(ent.ent_ready), 1);
        feed(32'h1, 32'h1, 12, 1'b0);
        chk("nom_partial_iv", iv, '0);
        wait_valid();
        chk("nom_latency", 384'(cyc), 14);
        chk("nom_iv", iv, NOM_IV);
        chk("nom_err", 384'(err), 0);
        chk("nom_busy_done", 384'(busy), 0);

        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_idle_iv", iv, '0);
        chk("zero_idle_valid", 384'(iv_valid), 0);

        start();
        feed(32'h1, 32'h1, 12, 1'b1);
        wait_valid();
        chk("bp_latency", 384'(cyc), 25);
        chk("bp_iv", iv, NOM_IV);

        start();
        feed(32'h1, 32'h1, 12, 1'b0);
        tick();
        chk("stuck_err", 384'(err), 1);
        chk("stuck_valid", 384'(iv_valid), 0);
        chk("stuck_iv", iv, '0);
        chk("stuck_ready", 384'(ent.ent_ready), 0);

        start();
        feed(32'h100, 32'h1, 12, 1'b0);
        wait_valid();
        chk("third_iv", iv, B100_IV);
        chk("third_err", 384'(err), 0);

        start();
        feed(32'hDEADBEEF, 32'h0, 3, 1'b0);
        feed(32'h1, 32'h1, 9, 1'b0);
        wait_valid();
        chk("rep3_err", 384'(err), 0);
        chk("rep3_iv", iv, REP_IV);

        start();
        feed(32'hDEADBEEF, 32'h0, 4, 1'b0);
        chk("rep4_err", 384'(err), 1);
        chk("rep4_ready", 384'(ent.ent_ready), 0);
        chk("rep4_iv", iv, '0);
        chk("rep4_busy", 384'(busy), 0);

        start();
        feed(32'h200, 32'h1, 5, 1'b0);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zmid_busy", 384'(busy), 0);
        chk("zmid_ready", 384'(ent.ent_ready), 0);
        chk("zmid_iv", iv, '0);
        chk("zmid_err", 384'(err), 0);
        start();
        feed(32'hDEADBEEF, 32'h0, 3, 1'b0);
        feed(32'h1, 32'h1, 9, 1'b0);
        wait_valid();
        chk("zpost_err", 384'(err), 0);
        chk("zpost_iv", iv, REP_IV);

        start();
        feed(32'h1, 32'h1, 3, 1'b0);
        req = 1'b1;
        feed(32'h4, 32'h1, 9, 1'b0);
        wait_valid();
        chk("reqmid_latency", 384'(cyc), 14);
        chk("reqmid_iv", iv, NOM_IV);

        zeroize = 1'b1;
        req = 1'b1;
        tick();
        zeroize = 1'b0;
        req = 1'b0;
        chk("zreq_busy", 384'(busy), 0);
        chk("zreq_valid", 384'(iv_valid), 0);

        start();
        feed(32'h300, 32'h1, 2, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 384'(busy), 0);
        chk("arst_ready", 384'(ent.ent_ready), 0);
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
